// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius (Simon) sequence controller.
package genius_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADD_STEP,
      SHOW_ON,
      SHOW_OFF,
      WAIT_INPUT,
      CHECK,
      WIN,
      LOSE
   } genius_state_t;

   // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0].
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/genius_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; exposes its low OUT_W bits as the next colour.
module genius_lfsr
   import genius_pkg::*;
#(
   parameter logic [15:0] SEED  = 16'hACE1,
   parameter int          OUT_W = 2
) (
   input  logic             clk,
   input  logic             rst_,
   output logic [OUT_W-1:0] rnd
);

   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
   end

   always_ff @(posedge clk) begin
      if (!rst_) lfsr_q <= SEED;
      else       lfsr_q <= lfsr_d;
   end

   assign rnd = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/genius_seq_controller.sv
// Genius (Simon) game controller: grows a random colour sequence, plays it back, checks the player.
// Define GENIUS_INPUT_TIMEOUT_EN to lose after 4*show_t idle cycles in WAIT_INPUT.
module genius_seq_controller
   import genius_pkg::*;
#(
   parameter int          NUM_COLORS = 4,
   parameter int          MAX_LEN    = 32,
   parameter int          SHOW_TICKS = 25_000_000,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                         clk,
   input  logic                         rst_,
   input  logic                         start_button,
   input  logic                         speed_button,
   input  logic                         dificulty_button,
   input  logic                         mode_game_button,
   input  logic [NUM_COLORS-1:0]        player_btn,
   output logic [NUM_COLORS-1:0]        led,
   output logic [1:0]                   speed_sel,
   output logic [1:0]                   diff_sel,
   output logic                         mode_sel,
   output logic [$clog2(MAX_LEN+1)-1:0] level,
   output logic                         busy,
   output logic                         win,
   output logic                         game_over
);

   localparam int CW = $clog2(NUM_COLORS);
   localparam int AW = $clog2(MAX_LEN);
   localparam int LW = $clog2(MAX_LEN + 1);
   localparam int TW = $clog2(SHOW_TICKS + 1);

   genius_state_t         state_q, state_d;
   logic [LW-1:0]         level_q, level_d, target_q, target_d;
   logic [AW-1:0]         idx_q, idx_d, ptr_q, ptr_d;
   logic [TW-1:0]         tick_q, tick_d, show_t_q, show_t_d, gap_t_q, gap_t_d;
   logic [1:0]            speed_q, speed_d, diff_q, diff_d;
   logic                  mode_q, mode_d;
   logic [NUM_COLORS-1:0] press_q, press_d;
   logic [CW-1:0]         mem_q [2**AW];
   logic                  mem_we;
   logic [CW-1:0]         new_color;
   logic                  last_entry;
`ifdef GENIUS_INPUT_TIMEOUT_EN
   localparam int OW = TW + 2;
   logic [OW-1:0]         to_cnt_q, to_cnt_d;
`endif

   function automatic logic [NUM_COLORS-1:0] onehot(input logic [CW-1:0] c);
      logic [NUM_COLORS-1:0] v;
      v    = '0;
      v[c] = 1'b1;
      return v;
   endfunction

   function automatic logic [LW-1:0] calc_target(input logic [1:0] d);
      int t;
      t = 8 * (int'(d) + 1);
      return (t > MAX_LEN) ? LW'(MAX_LEN) : LW'(t);
   endfunction

   // Very short SHOW_TICKS at high speed would shift to zero; keep at least one cycle.
   function automatic logic [TW-1:0] calc_show(input logic [1:0] s);
      logic [TW-1:0] t;
      t = TW'(SHOW_TICKS >> s);
      return (t == '0) ? TW'(1) : t;
   endfunction

   function automatic logic [TW-1:0] calc_gap(input logic [TW-1:0] s);
      return ((s >> 1) == '0) ? TW'(1) : (s >> 1);
   endfunction

   genius_lfsr #(.SEED(LFSR_SEED), .OUT_W(CW)) u_lfsr (
      .clk (clk),
      .rst_(rst_),
      .rnd (new_color)
   );

   assign last_entry = mode_q ? (ptr_q == '0) : (LW'(ptr_q) == level_q - LW'(1));

   // NOTE: every signal assigned below gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      level_d  = level_q;
      target_d = target_q;
      idx_d    = idx_q;
      ptr_d    = ptr_q;
      tick_d   = tick_q;
      show_t_d = show_t_q;
      gap_t_d  = gap_t_q;
      speed_d  = speed_q;
      diff_d   = diff_q;
      mode_d   = mode_q;
      press_d  = press_q;
      mem_we   = 1'b0;
`ifdef GENIUS_INPUT_TIMEOUT_EN
      to_cnt_d = to_cnt_q;
`endif
      case (state_q)
         IDLE, WIN, LOSE: begin
            if (speed_button)     speed_d = speed_q + 2'd1;
            if (dificulty_button) diff_d  = diff_q + 2'd1;
            if (mode_game_button) mode_d  = ~mode_q;
            if (start_button) begin
               state_d  = ADD_STEP;
               level_d  = '0;
               target_d = calc_target(diff_q);
               show_t_d = calc_show(speed_q);
               gap_t_d  = calc_gap(calc_show(speed_q));
            end
         end
         ADD_STEP: begin
            mem_we  = 1'b1;
            level_d = level_q + LW'(1);
            idx_d   = '0;
            tick_d  = '0;
            state_d = SHOW_ON;
         end
         SHOW_ON: begin
            if (tick_q == show_t_q - TW'(1)) begin
               tick_d  = '0;
               state_d = SHOW_OFF;
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end
         SHOW_OFF: begin
            if (tick_q == gap_t_q - TW'(1)) begin
               tick_d = '0;
               if (LW'(idx_q) + LW'(1) < level_q) begin
                  idx_d   = idx_q + AW'(1);
                  state_d = SHOW_ON;
               end else begin
                  ptr_d   = mode_q ? AW'(level_q - LW'(1)) : '0;
                  state_d = WAIT_INPUT;
`ifdef GENIUS_INPUT_TIMEOUT_EN
                  to_cnt_d = '0;
`endif
               end
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end
         WAIT_INPUT: begin
            if (player_btn != '0) begin
               press_d = player_btn;
               state_d = CHECK;
            end
`ifdef GENIUS_INPUT_TIMEOUT_EN
            else if (to_cnt_q == {show_t_q, 2'b00} - OW'(1)) begin
               state_d = LOSE;
            end else begin
               to_cnt_d = to_cnt_q + OW'(1);
            end
`endif
         end
         CHECK: begin
            // A multi-bit press can never equal a one-hot pattern, so it falls into LOSE here.
            if (press_q != onehot(mem_q[ptr_q])) begin
               state_d = LOSE;
            end else if (last_entry) begin
               state_d = (level_q == target_q) ? WIN : ADD_STEP;
            end else begin
               ptr_d   = mode_q ? ptr_q - AW'(1) : ptr_q + AW'(1);
               state_d = WAIT_INPUT;
`ifdef GENIUS_INPUT_TIMEOUT_EN
               to_cnt_d = '0;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_) begin
         state_q  <= IDLE;
         level_q  <= '0;
         target_q <= '0;
         idx_q    <= '0;
         ptr_q    <= '0;
         tick_q   <= '0;
         show_t_q <= TW'(1);
         gap_t_q  <= TW'(1);
         speed_q  <= '0;
         diff_q   <= '0;
         mode_q   <= 1'b0;
         press_q  <= '0;
`ifdef GENIUS_INPUT_TIMEOUT_EN
         to_cnt_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         level_q  <= level_d;
         target_q <= target_d;
         idx_q    <= idx_d;
         ptr_q    <= ptr_d;
         tick_q   <= tick_d;
         show_t_q <= show_t_d;
         gap_t_q  <= gap_t_d;
         speed_q  <= speed_d;
         diff_q   <= diff_d;
         mode_q   <= mode_d;
         press_q  <= press_d;
`ifdef GENIUS_INPUT_TIMEOUT_EN
         to_cnt_q <= to_cnt_d;
`endif
      end
   end

   // NOTE: the sequence memory is deliberately not reset; each entry is written before it is read.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[level_q[AW-1:0]] <= new_color;
   end

   always_comb begin
      led = '0;
      case (state_q)
         SHOW_ON: led = onehot(mem_q[idx_q]);
         WIN:     led = '1;
         LOSE:    led = onehot(mem_q[ptr_q]);
         default: led = '0;
      endcase
   end

   assign speed_sel = speed_q;
   assign diff_sel  = diff_q;
   assign mode_sel  = mode_q;
   assign level     = level_q;
   assign busy      = !(state_q inside {IDLE, WIN, LOSE});
   assign win       = (state_q == WIN);
   assign game_over = (state_q == LOSE);

endmodule

// File: doc/genius_seq_controller.md
Name: genius_seq_controller

Overview:
- Parametrised game controller for the Genius (Simon) game.
- Owns the sequence memory and a free-running LFSR colour generator.
- Plays the sequence back on the colour LEDs, then checks the player's button presses against it.
- Sits between the debounced button front-end and the LED/score display logic. Supports N colours, configurable maximum length, speed and difficulty, and a reverse-entry game mode.

Parameters:
- NUM_COLORS, 4, number of colour channels (power of 2, 2..16)
- MAX_LEN, 32, sequence memory depth (maximum rounds)
- SHOW_TICKS, 25_000_000, clk cycles a colour is lit at speed 0
- LFSR_SEED, 16'hACE1, non-zero LFSR reset value

Ports:
- clk  in  1  system clock
- rst_  in  1  synchronous reset, active-low
- start_button  in  1  single-cycle pulse: start/restart game
- speed_button  in  1  pulse: cycle speed_sel 0->1->2->3->0
- dificulty_button  in  1  pulse: cycle diff_sel 0->1->2->3->0
- mode_game_button  in  1  pulse: toggle mode_sel
- player_btn  in  NUM_COLORS  debounced single-cycle pulses, one bit per colour
- led  out  NUM_COLORS  colour LEDs, one-hot or zero
- speed_sel  out  2  current speed setting
- diff_sel  out  2  current difficulty setting
- mode_sel  out  1  0 = classic, 1 = reverse entry
- level  out  $clog2(MAX_LEN+1)  current sequence length
- busy  out  1  high outside IDLE/WIN/LOSE
- win  out  1  high in WIN state
- game_over  out  1  high in LOSE state

Behaviour:
- Reset (rst_ low at posedge clk):
  - state=IDLE; led=0; level=0; speed_sel=0; diff_sel=0; mode_sel=0; win=0; game_over=0.
  - LFSR=LFSR_SEED; tick counter=0.
  - Reset mid-game aborts immediately; sequence memory contents are don't-care.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle in all states. New colour = LFSR[$clog2(NUM_COLORS)-1:0].
- Settings buttons act only in IDLE, WIN and LOSE; ignored while busy.
- Derived values, registered when start_button is accepted:
  - target = min(8*(diff_sel+1), MAX_LEN)
  - show_t = SHOW_TICKS >> speed_sel
  - gap_t = show_t >> 1, minimum 1
- States:
  - IDLE/WIN/LOSE: start_button -> ADD_STEP with level=0.
  - ADD_STEP (1 cycle): mem[level] <= new colour; level <= level+1 -> SHOW_ON with idx=0.
  - SHOW_ON: led = onehot(mem[idx]) for show_t cycles -> SHOW_OFF.
  - SHOW_OFF: led=0 for gap_t cycles; then idx+1 < level -> SHOW_ON with idx+1, else -> WAIT_INPUT.
  - WAIT_INPUT: expected pointer ptr = 0 (mode 0) or level-1 (mode 1). On any player_btn != 0 -> CHECK with the press latched.
  - CHECK (1 cycle):
    - Press must equal onehot(mem[ptr]); a multi-bit press is always wrong.
    - Wrong -> LOSE.
    - Correct and not last entry -> WAIT_INPUT, ptr advanced (+1 mode 0, -1 mode 1).
    - Correct and last entry: level == target -> WIN, else ADD_STEP.
  - WIN: led = all ones. LOSE: led = onehot(mem[ptr]), showing the correct colour.
- Latency:
  - One player press is accepted per CHECK.
  - A press arriving in the same cycle as entry to WAIT_INPUT is accepted.
  - Presses during SHOW_ON/SHOW_OFF/CHECK are ignored.
- start_button while busy is ignored.
- level never exceeds MAX_LEN, because target <= MAX_LEN.

Optional Feature:
- GENIUS_INPUT_TIMEOUT_EN
  - Defined: WAIT_INPUT counts cycles since entry. Reaching 4*show_t cycles with no press -> LOSE. The counter is cleared on every entry to WAIT_INPUT.
  - Undefined: WAIT_INPUT waits indefinitely; no timeout counter is synthesised.

Decomposition:
- Shared package typedefs: genius_state_t enum (IDLE, ADD_STEP, SHOW_ON, SHOW_OFF, WAIT_INPUT, CHECK, WIN, LOSE) and the LFSR tap constant.
- Sub-module genius_lfsr: free-running LFSR with seed parameter.
- Sequence memory and tick counter stay inline.

Test Plan:
- Reset, then 2 speed_button and 1 dificulty_button pulses in IDLE -> speed_sel=2, diff_sel=1. After start, SHOW_ON lasts SHOW_TICKS/4 cycles and the WIN target is 16.
- SHOW_TICKS=8, diff 0, mode 0: bench records the colour shown each round and replays it correctly -> level steps 1..8, then win=1, led all ones, busy=0.
- Round 3, wrong colour on second press -> game_over=1, led shows the expected colour, level=3.
- mode_sel=1, level 3 with sequence {A,B,C}: press C,B,A -> ADD_STEP. Press A first -> LOSE.
- Press two colours in the same cycle -> LOSE. rst_ low mid SHOW_ON -> all outputs at reset values next cycle.
- GENIUS_INPUT_TIMEOUT_EN defined, SHOW_TICKS=8: no press for 32 cycles in WAIT_INPUT -> LOSE. Undefined: no press for 1000 cycles -> still WAIT_INPUT.
